// File: rtl/clarvi_slice_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : clarvi_slice_sequencer
//  Purpose  : Issue side of the 16-bit sliced ALU. Takes one full 64-bit (or
//             RV64 32-bit "W") operation, drives the ALU for four beats with
//             one 16-bit operand slice per beat in the part order the op
//             needs, and collects the four 16-bit results into a 64-bit
//             writeback value.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   1        clock
//    reset          in   1        synchronous, active-low
//    req_valid_i    in   1        operation request valid
//    req_ready_o    out  1        sequencer can accept a request
//    req_instr_i    in   instr_t  decoded instruction (instr_part ignored)
//    req_rs1_i      in   64       full rs1 value
//    req_rs2_i      in   64       full rs2 value
//    alu_instr_o    out  instr_t  latched instruction, instr_part per beat
//    alu_rs1_o      out  SLICE_W  rs1 slice for the current part
//    alu_rs2_o      out  SLICE_W  rs2 slice for the current part
//    alu_stall_o    out  1        low only on issue beats
//    alu_result_i   in   SLICE_W  ALU combinational result for this beat
//    rsp_valid_o    out  1        assembled result valid
//    rsp_ready_i    in   1        consumer takes the result
//    rsp_result_o   out  64       assembled result
// ============================================================================

// Shared decoded-instruction types. They live in the compilation unit so the
// ALU, the sequencer and their users see one definition.
typedef enum logic [3:0] {
  OP_ADD  = 4'd0,
  OP_SUB  = 4'd1,
  OP_SLT  = 4'd2,
  OP_SLTU = 4'd3,
  OP_XOR  = 4'd4,
  OP_OR   = 4'd5,
  OP_AND  = 4'd6,
  OP_SLL  = 4'd7,
  OP_SRL  = 4'd8,
  OP_SRA  = 4'd9
} alu_op_e;

typedef struct packed {
  alu_op_e     op;
  logic        is32_bit_op;
  logic [63:0] immediate;
  logic [63:0] pc;
  logic [1:0]  instr_part;
} instr_t;

module clarvi_slice_sequencer #(
  parameter int SLICE_W     = 16,    // only 16 is supported (four parts)
  parameter bit EARLY_READY = 1'b0   // accept a new op in RESP when rsp_ready_i
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  instr_t             req_instr_i,
  input  logic [63:0]        req_rs1_i,
  input  logic [63:0]        req_rs2_i,
  output instr_t             alu_instr_o,
  output logic [SLICE_W-1:0] alu_rs1_o,
  output logic [SLICE_W-1:0] alu_rs2_o,
  output logic               alu_stall_o,
  input  logic [SLICE_W-1:0] alu_result_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [63:0]        rsp_result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  beat_q,  beat_d;
  instr_t      instr_q, instr_d;
  logic [63:0] rs1_q,   rs1_d;
  logic [63:0] rs2_q,   rs2_d;
  logic [63:0] res_q,   res_d;

  logic [1:0]  part;        // slice index driven on this beat
  logic [5:0]  slice_lsb;   // bit offset of that slice

  // --------------------------------------------------------------------------
  // Part order. Comparisons resolve from the most significant slice down, and
  // right shifts need the higher slices before the lower ones. For W shifts
  // the low word is done high-half first, then the upper parts (which the ALU
  // fills with sign extension) follow. ~k is 3-k for a 2-bit counter, and
  // flipping bit 0 gives the 1,0,3,2 order.
  // --------------------------------------------------------------------------
  always_comb begin
    part = beat_q;
    if ((instr_q.op == OP_SLT) || (instr_q.op == OP_SLTU)) begin
      part = ~beat_q;
    end else if ((instr_q.op == OP_SRL) || (instr_q.op == OP_SRA)) begin
      part = instr_q.is32_bit_op ? {beat_q[1], ~beat_q[0]} : ~beat_q;
    end
  end

  assign slice_lsb = {part, 4'b0000};

  // Slices and instruction always reflect the latched op, so nothing the ALU
  // sees is ever undefined, even while it is stalled.
  assign alu_rs1_o    = rs1_q[slice_lsb +: SLICE_W];
  assign alu_rs2_o    = rs2_q[slice_lsb +: SLICE_W];
  assign rsp_result_o = res_q;

  always_comb begin
    alu_instr_o            = instr_q;
    alu_instr_o.instr_part = part;
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    instr_d     = instr_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    res_d       = res_q;
    req_ready_o = 1'b0;
    alu_stall_o = 1'b1;
    rsp_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          instr_d = req_instr_i;
          rs1_d   = req_rs1_i;
          rs2_d   = req_rs2_i;
          beat_d  = 2'd0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        alu_stall_o                   = 1'b0;
        res_d[slice_lsb +: SLICE_W]   = alu_result_i;
        if (beat_q == 2'd3) begin
          state_d = S_RESP;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end

      S_RESP: begin
        rsp_valid_o = 1'b1;
        req_ready_o = EARLY_READY && rsp_ready_i;
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          if (EARLY_READY && req_valid_i) begin
            instr_d = req_instr_i;
            rs1_d   = req_rs1_i;
            rs2_d   = req_rs2_i;
            beat_d  = 2'd0;
            state_d = S_ISSUE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers; reset discards any op in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      instr_q <= '0;
      rs1_q   <= 64'd0;
      rs2_q   <= 64'd0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
    end
  end

endmodule

`default_nettype wire
